// File: rtl/decode_ctrl_if.sv
// Bundled stream/decoder/RAM signals around the decode sequencer.
// master = sequencer side, slave = upstream source, decoder and poly RAM.
interface decode_ctrl_if #(
   parameter int W          = 64,
   parameter int COEFF_W    = 23,
   parameter int OUTPUT_W   = 4,
   parameter int POLY_IDX_W = 3
);
   logic [W-1:0]                  src_data;
   logic                          src_valid;
   logic                          src_ready;
   logic                          dec_rst;
   logic [2:0]                    dec_sec_lvl;
   logic [2:0]                    dec_mode;
   logic [W-1:0]                  dec_di;
   logic                          dec_valid_i;
   logic                          dec_ready_i;
   logic [OUTPUT_W*COEFF_W-1:0]   dec_samples;
   logic                          dec_valid_o;
   logic                          dec_ready_o;
   logic                          wr_en;
   logic [POLY_IDX_W+5:0]         wr_addr;
   logic [OUTPUT_W*COEFF_W-1:0]   wr_data;
   logic                          wr_ready;

   modport master (
      input  src_data, src_valid, dec_ready_i, dec_samples, dec_valid_o, wr_ready,
      output src_ready, dec_rst, dec_sec_lvl, dec_mode, dec_di, dec_valid_i,
             dec_ready_o, wr_en, wr_addr, wr_data
   );

   modport slave (
      output src_data, src_valid, dec_ready_i, dec_samples, dec_valid_o, wr_ready,
      input  src_ready, dec_rst, dec_sec_lvl, dec_mode, dec_di, dec_valid_i,
             dec_ready_o, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/decode_ctrl.sv
// Command sequencer for the unpack/decode datapath: meters packed words into
// the decoder and streams 4-coefficient beats to poly RAM at sequential addresses.
module decode_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   sec_lvl,
   input  logic [2:0]   encode_mode,
   input  logic [3:0]   num_poly,
   input  logic         abort,
   output logic         busy,
   output logic         done,
   output logic         err,
   decode_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_SETUP, S_RUN, S_DONE, S_ERR, S_CLR_ABORT
   } state_t;

   state_t       state, state_nx;
   logic [2:0]   sec_q, mode_q;
   logic [3:0]   npoly_q;
   logic [4:0]   lvl;
   logic [10:0]  words_total;
   logic [9:0]   words_left;
   logic [5:0]   beat;
   logic [2:0]   poly_idx;
   logic         dec_rst_q;
   logic         illegal, in_xfer, last_wr;
   logic         src_ready, dec_valid_i, dec_ready_o, wr_en;

   // Bits per coefficient; unsupported security levels make every mode illegal.
   always_comb begin
      lvl = '0;
      if (sec_q == 3'd2 || sec_q == 3'd3 || sec_q == 3'd5) begin
         case (mode_q)
            3'd0:       lvl = 5'd13;
            3'd1:       lvl = 5'd10;
            3'd2, 3'd3: lvl = (sec_q == 3'd3) ? 5'd4 : 5'd3;
            3'd4:       lvl = (sec_q == 3'd2) ? 5'd6 : 5'd4;
            3'd5:       lvl = (sec_q == 3'd2) ? 5'd18 : 5'd20;
            default:    lvl = '0;
         endcase
      end
   end

   assign words_total = ({7'd0, npoly_q} * {6'd0, lvl}) << 2;
   // More than 8 polynomials cannot be addressed by the 3-bit index, so never start it.
   assign illegal     = (lvl == 5'd0) || (npoly_q > 4'd8);

   always_comb begin
      state_nx    = state;
      src_ready   = 1'b0;
      dec_valid_i = 1'b0;
      dec_ready_o = 1'b0;
      wr_en       = 1'b0;
      in_xfer     = 1'b0;
      last_wr     = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_CLR;
         S_CLR: begin
            if (abort)                 state_nx = S_CLR_ABORT;
            else if (illegal)          state_nx = S_ERR;
            else if (npoly_q == 4'd0)  state_nx = S_DONE;
            else                       state_nx = S_SETUP;
         end
         S_SETUP: state_nx = abort ? S_CLR_ABORT : S_RUN;
         S_RUN: begin
            if (words_left != 10'd0) begin
               dec_valid_i = bus.src_valid;
               src_ready   = bus.dec_ready_i;
            end
            in_xfer     = dec_valid_i & src_ready;
            dec_ready_o = bus.wr_ready;
            wr_en       = bus.dec_valid_o & bus.wr_ready;
            last_wr     = wr_en && (beat == 6'd63) && ({1'b0, poly_idx} == npoly_q - 4'd1);
            if (abort)        state_nx = S_CLR_ABORT;
            else if (last_wr) state_nx = S_DONE;
         end
         S_DONE, S_ERR, S_CLR_ABORT: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         dec_rst_q  <= 1'b1;
         sec_q      <= '0;
         mode_q     <= '0;
         npoly_q    <= '0;
         words_left <= '0;
         beat       <= '0;
         poly_idx   <= '0;
      end else begin
         state     <= state_nx;
         dec_rst_q <= (state_nx == S_CLR) || (state_nx == S_CLR_ABORT);
         if (state == S_IDLE && start) begin
            sec_q   <= sec_lvl;
            mode_q  <= encode_mode;
            npoly_q <= num_poly;
         end
         case (state)
            S_CLR: begin
               words_left <= words_total[9:0];
               beat       <= '0;
               poly_idx   <= '0;
            end
            S_SETUP: ;
            S_RUN: begin
               if (in_xfer) words_left <= words_left - 10'd1;
               if (wr_en)   {poly_idx, beat} <= {poly_idx, beat} + 9'd1;
            end
            default: begin
               words_left <= '0;
               beat       <= '0;
               poly_idx   <= '0;
            end
         endcase
      end
   end

   assign busy            = (state != S_IDLE);
   assign done            = (state == S_DONE);
   assign err             = (state == S_ERR);
   assign bus.dec_rst     = dec_rst_q;
   assign bus.dec_sec_lvl = sec_q;
   assign bus.dec_mode    = mode_q;
   assign bus.dec_di      = bus.src_data;
   assign bus.src_ready   = src_ready;
   assign bus.dec_valid_i = dec_valid_i;
   assign bus.dec_ready_o = dec_ready_o;
   assign bus.wr_en       = wr_en;
   assign bus.wr_addr     = {poly_idx, beat};
   assign bus.wr_data     = bus.dec_samples;
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl with a bit-pool decoder stand-in.
module tb_decode_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [2:0]  sec_lvl, encode_mode;
   logic [3:0]  num_poly;
   logic        busy, done, err;

   decode_ctrl_if bus ();

   decode_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sec_lvl(sec_lvl),
      .encode_mode(encode_mode), .num_poly(num_poly), .abort(abort),
      .busy(busy), .done(done), .err(err), .bus(bus)
   );

   always #5 clk = ~clk;

   // Decoder stand-in: 64 bits in per word, 4*LVL bits out per beat.
   int          bpb;
   int          pool;
   logic [22:0] samp;
   logic        phase, tog_en;
   logic        in_x, out_x;

   assign in_x            = bus.dec_valid_i & bus.dec_ready_i;
   assign out_x           = bus.dec_valid_o & bus.dec_ready_o;
   assign bus.src_valid   = 1'b1;
   assign bus.src_data    = {32'hC0DE_0000, pool};
   assign bus.dec_ready_i = (pool < 128);
   assign bus.dec_valid_o = (bpb != 0) && (pool >= bpb);
   assign bus.dec_samples = {4{samp}};
   assign bus.wr_ready    = tog_en ? phase : 1'b1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pool  <= 0;
         samp  <= '0;
         phase <= 1'b0;
      end else begin
         phase <= ~phase;
         if (bus.dec_rst) begin
            pool <= 0;
            samp <= '0;
         end else begin
            pool <= pool + (in_x ? 64 : 0) - (out_x ? bpb : 0);
            if (out_x) samp <= samp + 23'd1;
         end
      end
   end

   // Per-command activity record
   logic        clr_req;
   int          words_n, wr_n, done_n, err_n, busy_n;
   int          addr_bad, data_bad, nordy_bad, late_busy;
   logic [8:0]  last_addr;
   logic        done_prev;

   always @(negedge clk) begin
      if (clr_req) begin
         words_n <= 0; wr_n <= 0; done_n <= 0; err_n <= 0; busy_n <= 0;
         addr_bad <= 0; data_bad <= 0; nordy_bad <= 0; late_busy <= 0;
         last_addr <= '0; done_prev <= 1'b0;
      end else begin
         if (bus.src_valid && bus.src_ready) words_n <= words_n + 1;
         if (bus.wr_en) begin
            if (bus.wr_addr !== 9'(wr_n))            addr_bad  <= addr_bad + 1;
            if (bus.wr_data !== {4{23'(wr_n)}})      data_bad  <= data_bad + 1;
            if (bus.wr_ready !== 1'b1)               nordy_bad <= nordy_bad + 1;
            last_addr <= bus.wr_addr;
            wr_n      <= wr_n + 1;
         end
         if (done) done_n <= done_n + 1;
         if (err)  err_n  <= err_n + 1;
         if (busy) busy_n <= busy_n + 1;
         if (done_prev && busy) late_busy <= late_busy + 1;
         done_prev <= done;
      end
   end

   int n_cmp, n_bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] s, input logic [2:0] m, input logic [3:0] np,
                          input int b);
      bpb     = b;
      clr_req = 1'b1;
      @(negedge clk); #1;
      clr_req     = 1'b0;
      start       = 1'b1;
      sec_lvl     = s;
      encode_mode = m;
      num_poly    = np;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (busy && n < bound);
      chk({tag, "_timeout"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic chk_run(input string tag, input int w, input int wr, input int dn,
                          input int er, input logic [8:0] la);
      chk({tag, "_words"},  64'(words_n),  64'(w));
      chk({tag, "_writes"}, 64'(wr_n),     64'(wr));
      chk({tag, "_done"},   64'(done_n),   64'(dn));
      chk({tag, "_err"},    64'(err_n),    64'(er));
      chk({tag, "_addr"},   64'(addr_bad), 64'd0);
      chk({tag, "_data"},   64'(data_bad), 64'd0);
      chk({tag, "_late"},   64'(late_busy), 64'd0);
      if (wr > 0) chk({tag, "_last"}, 64'(last_addr), 64'(la));
   endtask

   localparam logic [13:0] RST_VEC = 14'b0001_0000_000_000;

   initial begin
      n_cmp = 0; n_bad = 0;
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; tog_en = 1'b0; clr_req = 1'b1;
      sec_lvl = '0; encode_mode = '0; num_poly = '0; bpb = 0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_outs", 64'({busy, done, err, bus.dec_rst, bus.src_ready, bus.dec_valid_i,
                             bus.dec_ready_o, bus.wr_en, bus.dec_sec_lvl, bus.dec_mode}),
          64'(RST_VEC));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("idle_flush", {62'd0, busy, bus.dec_rst}, 64'd0);

      // sec 2, T1, one polynomial: 40 words, 64 beats
      run_cmd(3'd2, 3'd1, 4'd1, 40);
      wait_idle("t1", 1000);
      chk_run("t1", 40, 64, 1, 0, 9'h03F);
      chk("t1_cfg", 64'({bus.dec_sec_lvl, bus.dec_mode}), 64'({3'd2, 3'd1}));

      // sec 3, Z, five polynomials; a second start mid-run must be ignored
      run_cmd(3'd3, 3'd5, 4'd5, 80);
      repeat (10) @(negedge clk);
      #1;
      chk("z_di", bus.dec_di, bus.src_data);
      start = 1'b1; sec_lvl = 3'd2; encode_mode = 3'd0; num_poly = 4'd1;
      @(negedge clk); #1;
      start = 1'b0;
      wait_idle("z", 3000);
      chk_run("z", 400, 320, 1, 0, 9'h13F);
      chk("z_cfg", 64'({bus.dec_sec_lvl, bus.dec_mode}), 64'({3'd3, 3'd5}));

      // sec 4 is not a valid level: err, no words, CLR+ERR busy
      run_cmd(3'd4, 3'd0, 4'd1, 52);
      wait_idle("bad", 50);
      chk_run("bad", 0, 0, 0, 1, 9'h000);
      chk("bad_busy", 64'(busy_n), 64'd2);

      // zero polynomials: straight to DONE
      run_cmd(3'd2, 3'd1, 4'd0, 40);
      wait_idle("np0", 50);
      chk_run("np0", 0, 0, 1, 0, 9'h000);
      chk("np0_busy", 64'(busy_n), 64'd2);

      // sec 5, S1, two polynomials with RAM back-pressure every other cycle
      tog_en = 1'b1;
      run_cmd(3'd5, 3'd2, 4'd2, 12);
      wait_idle("s1", 2000);
      tog_en = 1'b0;
      chk_run("s1", 24, 128, 1, 0, 9'h07F);
      chk("s1_nordy", 64'(nordy_bad), 64'd0);

      // abort once 20 beats are written
      begin
         int n;
         run_cmd(3'd2, 3'd0, 4'd1, 52);
         n = 0;
         do begin
            @(negedge clk); #1;
            n++;
         end while (wr_n < 20 && n < 500);
         chk("abort_reach", 64'(wr_n >= 20), 64'd1);
         abort = 1'b1;
         @(posedge clk); #1;
         abort = 1'b0;
         chk("abort_flush", {62'd0, bus.dec_rst, busy}, 64'd3);
         @(posedge clk); #1;
         chk("abort_idle", {62'd0, bus.dec_rst, busy}, 64'd0);
         @(negedge clk); #1;
         chk("abort_nodone", 64'(done_n + err_n), 64'd0);
         chk("abort_partial", 64'(wr_n < 64), 64'd1);
      end
      run_cmd(3'd2, 3'd1, 4'd1, 40);
      wait_idle("post", 1000);
      chk_run("post", 40, 64, 1, 0, 9'h03F);

      // async reset in the middle of a run
      run_cmd(3'd3, 3'd5, 4'd1, 80);
      repeat (30) @(negedge clk);
      #1;
      chk("mid_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset", 64'({busy, done, err, bus.dec_rst, bus.src_ready, bus.dec_valid_i,
                            bus.dec_ready_o, bus.wr_en, bus.dec_sec_lvl, bus.dec_mode}),
          64'(RST_VEC));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("mid_idle", {63'd0, busy}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
